// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, store-data pass-through
// and the EXE/MEM pipeline latch.
// Optional macro FORWARDING_EN adds a MEM/WB -> EXE operand bypass and a
// combinational result port so that ID can bypass from this stage.
module exe_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    input  logic        Branch_prediction_IN,
`ifdef FORWARDING_EN
    input  logic [4:0]  RegisterA1_IN,
    input  logic [4:0]  RegisterB1_IN,
    input  logic [4:0]  BypassReg1_MEMEXE,
    input  logic [31:0] BypassData1_MEMEXE,
    input  logic        BypassValid1_MEMEXE,
    output logic [31:0] ALU_result_async1,
    output logic        ALU_result_async_valid1,
`endif
    input  logic [31:0] OperandA1_IN,
    input  logic [31:0] OperandB1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [4:0]  ShiftAmount1_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] ALU_result1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic [31:0] MemWriteData1_OUT,
    output logic        RegWrite1_OUT,
    output logic [5:0]  ALU_Control1_OUT,
    output logic        MemRead1_OUT,
    output logic        MemWrite1_OUT,
    output logic [31:0] Alt_PC1,
    output logic        Request_Alt_PC1,
    output logic        Branch_prediction_OUT
);

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_store_data;
    logic [31:0] w_alu_result;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_result;
    logic [4:0]  r_wreg;
    logic [31:0] r_store_data;
    logic        r_reg_write;
    logic [5:0]  r_alu_ctl;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_alt_pc;
    logic        r_req_alt_pc;
    logic        r_pred;

`ifdef FORWARDING_EN
    logic w_fwd_a;
    logic w_fwd_b;

    // Effective operands: MEM/WB bypass wins over ID operands; $zero never forwards
    always_comb begin
        w_fwd_a      = BypassValid1_MEMEXE && (BypassReg1_MEMEXE == RegisterA1_IN) &&
                       (RegisterA1_IN != 5'd0);
        w_fwd_b      = BypassValid1_MEMEXE && (BypassReg1_MEMEXE == RegisterB1_IN) &&
                       (RegisterB1_IN != 5'd0);
        w_op_a       = w_fwd_a ? BypassData1_MEMEXE : OperandA1_IN;
        w_op_b       = w_fwd_b ? BypassData1_MEMEXE : OperandB1_IN;
        w_store_data = (w_fwd_b && MemWrite1_IN) ? BypassData1_MEMEXE : MemWriteData1_IN;
    end

    // Bypass to ID: loads have no value yet, squashed instructions never write
    always_comb begin
        ALU_result_async1       = w_alu_result;
        ALU_result_async_valid1 = RegWrite1_IN & ~MemRead1_IN & ~FLUSH;
    end
`else
    // Effective operands are the ID operands as delivered
    always_comb begin
        w_op_a       = OperandA1_IN;
        w_op_b       = OperandB1_IN;
        w_store_data = MemWriteData1_IN;
    end
`endif

    // ALU: 32-bit, no overflow traps, unknown codes give zero
    always_comb begin
        w_alu_result = 32'd0;
        case (ALU_Control1_IN)
            6'd0, 6'd1: w_alu_result = w_op_a + w_op_b;
            6'd2, 6'd3: w_alu_result = w_op_a - w_op_b;
            6'd4:       w_alu_result = w_op_a & w_op_b;
            6'd5:       w_alu_result = w_op_a | w_op_b;
            6'd6:       w_alu_result = w_op_a ^ w_op_b;
            6'd7:       w_alu_result = ~(w_op_a | w_op_b);
            6'd8:       w_alu_result = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            6'd9:       w_alu_result = {31'd0, w_op_a < w_op_b};
            6'd10:      w_alu_result = w_op_b << ShiftAmount1_IN;
            6'd11:      w_alu_result = w_op_b >> ShiftAmount1_IN;
            6'd12:      w_alu_result = $unsigned($signed(w_op_b) >>> ShiftAmount1_IN);
            6'd13:      w_alu_result = w_op_b << w_op_a[4:0];
            6'd14:      w_alu_result = w_op_b >> w_op_a[4:0];
            6'd15:      w_alu_result = $unsigned($signed(w_op_b) >>> w_op_a[4:0]);
            6'd16:      w_alu_result = {w_op_b[15:0], 16'd0};
            6'd17:      w_alu_result = Instr1_PC_IN + 32'd8;
            default:    w_alu_result = 32'd0;
        endcase
    end

    // EXE/MEM latch: reset and flush both load an all-zero bubble
    always_ff @(posedge CLK) begin
        if (!RESET || FLUSH) begin
            r_instr      <= 32'd0;
            r_pc         <= 32'd0;
            r_result     <= 32'd0;
            r_wreg       <= 5'd0;
            r_store_data <= 32'd0;
            r_reg_write  <= 1'b0;
            r_alu_ctl    <= 6'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alt_pc     <= 32'd0;
            r_req_alt_pc <= 1'b0;
            r_pred       <= 1'b0;
        end else begin
            r_instr      <= Instr1_IN;
            r_pc         <= Instr1_PC_IN;
            r_result     <= w_alu_result;
            r_wreg       <= WriteRegister1_IN;
            r_store_data <= w_store_data;
            r_reg_write  <= RegWrite1_IN;
            r_alu_ctl    <= ALU_Control1_IN;
            r_mem_read   <= MemRead1_IN;
            r_mem_write  <= MemWrite1_IN;
            r_alt_pc     <= Alt_PC;
            r_req_alt_pc <= Request_Alt_PC;
            r_pred       <= Branch_prediction_IN;
        end
    end

    // Registered outputs
    always_comb begin
        Instr1_OUT            = r_instr;
        Instr1_PC_OUT         = r_pc;
        ALU_result1_OUT       = r_result;
        WriteRegister1_OUT    = r_wreg;
        MemWriteData1_OUT     = r_store_data;
        RegWrite1_OUT         = r_reg_write;
        ALU_Control1_OUT      = r_alu_ctl;
        MemRead1_OUT          = r_mem_read;
        MemWrite1_OUT         = r_mem_write;
        Alt_PC1               = r_alt_pc;
        Request_Alt_PC1       = r_req_alt_pc;
        Branch_prediction_OUT = r_pred;
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_exe_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FLUSH = 1'b0;
    logic [31:0] Instr1_IN = '0;
    logic [31:0] Instr1_PC_IN = '0;
    logic        Request_Alt_PC = 1'b0;
    logic [31:0] Alt_PC = '0;
    logic        Branch_prediction_IN = 1'b0;
    logic [4:0]  RegisterA1_IN = '0;
    logic [4:0]  RegisterB1_IN = '0;
    logic [31:0] OperandA1_IN = '0;
    logic [31:0] OperandB1_IN = '0;
    logic [4:0]  WriteRegister1_IN = '0;
    logic [31:0] MemWriteData1_IN = '0;
    logic        RegWrite1_IN = 1'b0;
    logic [5:0]  ALU_Control1_IN = '0;
    logic        MemRead1_IN = 1'b0;
    logic        MemWrite1_IN = 1'b0;
    logic [4:0]  ShiftAmount1_IN = '0;
    logic [4:0]  BypassReg1_MEMEXE = '0;
    logic [31:0] BypassData1_MEMEXE = '0;
    logic        BypassValid1_MEMEXE = 1'b0;

    logic [31:0] Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT, Alt_PC1;
    logic [4:0]  WriteRegister1_OUT;
    logic [5:0]  ALU_Control1_OUT;
    logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT, Request_Alt_PC1;
    logic        Branch_prediction_OUT;
    logic [31:0] ALU_result_async1;
    logic        ALU_result_async_valid1;

    int n_cmp = 0;
    int n_err = 0;

    exe_stage dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .FLUSH                  (FLUSH),
        .Instr1_IN              (Instr1_IN),
        .Instr1_PC_IN           (Instr1_PC_IN),
        .Request_Alt_PC         (Request_Alt_PC),
        .Alt_PC                 (Alt_PC),
        .Branch_prediction_IN   (Branch_prediction_IN),
`ifdef FORWARDING_EN
        .RegisterA1_IN          (RegisterA1_IN),
        .RegisterB1_IN          (RegisterB1_IN),
        .BypassReg1_MEMEXE      (BypassReg1_MEMEXE),
        .BypassData1_MEMEXE     (BypassData1_MEMEXE),
        .BypassValid1_MEMEXE    (BypassValid1_MEMEXE),
        .ALU_result_async1      (ALU_result_async1),
        .ALU_result_async_valid1(ALU_result_async_valid1),
`endif
        .OperandA1_IN           (OperandA1_IN),
        .OperandB1_IN           (OperandB1_IN),
        .WriteRegister1_IN      (WriteRegister1_IN),
        .MemWriteData1_IN       (MemWriteData1_IN),
        .RegWrite1_IN           (RegWrite1_IN),
        .ALU_Control1_IN        (ALU_Control1_IN),
        .MemRead1_IN            (MemRead1_IN),
        .MemWrite1_IN           (MemWrite1_IN),
        .ShiftAmount1_IN        (ShiftAmount1_IN),
        .Instr1_OUT             (Instr1_OUT),
        .Instr1_PC_OUT          (Instr1_PC_OUT),
        .ALU_result1_OUT        (ALU_result1_OUT),
        .WriteRegister1_OUT     (WriteRegister1_OUT),
        .MemWriteData1_OUT      (MemWriteData1_OUT),
        .RegWrite1_OUT          (RegWrite1_OUT),
        .ALU_Control1_OUT       (ALU_Control1_OUT),
        .MemRead1_OUT           (MemRead1_OUT),
        .MemWrite1_OUT          (MemWrite1_OUT),
        .Alt_PC1                (Alt_PC1),
        .Request_Alt_PC1        (Request_Alt_PC1),
        .Branch_prediction_OUT  (Branch_prediction_OUT)
    );

`ifndef FORWARDING_EN
    assign ALU_result_async1       = 32'd0;
    assign ALU_result_async_valid1 = 1'b0;
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] shr_arith(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v >> n;
        if (v[31]) r = r | ~(32'hFFFF_FFFF >> n);
        return r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh,
                                            input logic [31:0] pc);
        int n;
        int va;
        n = int'(a[4:0]);
        va = int'(sh);
        case (op)
            6'd0, 6'd1: return a + b;
            6'd2, 6'd3: return a + ~b + 32'd1;
            6'd4:  return a & b;
            6'd5:  return a | b;
            6'd6:  return a ^ b;
            6'd7:  return ~(a | b);
            6'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            6'd9:  return (a < b) ? 32'd1 : 32'd0;
            6'd10: return b << va;
            6'd11: return b >> va;
            6'd12: return shr_arith(b, va);
            6'd13: return b << n;
            6'd14: return b >> n;
            6'd15: return shr_arith(b, n);
            6'd16: return b * 32'h0001_0000;
            6'd17: return pc + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic fwd_hit(input logic [4:0] r);
`ifdef FORWARDING_EN
        return BypassValid1_MEMEXE && r != 5'd0 && r == BypassReg1_MEMEXE;
`else
        return r != r;
`endif
    endfunction

    function automatic logic [31:0] eff_a();
        return fwd_hit(RegisterA1_IN) ? BypassData1_MEMEXE : OperandA1_IN;
    endfunction

    function automatic logic [31:0] eff_b();
        return fwd_hit(RegisterB1_IN) ? BypassData1_MEMEXE : OperandB1_IN;
    endfunction

    function automatic logic [31:0] model_result();
        return alu_ref(ALU_Control1_IN, eff_a(), eff_b(), ShiftAmount1_IN, Instr1_PC_IN);
    endfunction

    logic [31:0] m_instr, m_pc, m_res, m_mwd, m_alt;
    logic [4:0]  m_wreg;
    logic [5:0]  m_ctl;
    logic        m_rw, m_mr, m_mw, m_req, m_pred;
    logic        m_started = 1'b0;

    always @(posedge CLK) begin
        m_started <= 1'b1;
        if (!RESET || FLUSH) begin
            m_instr <= '0; m_pc <= '0; m_res <= '0; m_mwd <= '0; m_alt <= '0;
            m_wreg <= '0; m_ctl <= '0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
            m_req <= 1'b0; m_pred <= 1'b0;
        end else begin
            m_instr <= Instr1_IN;
            m_pc    <= Instr1_PC_IN;
            m_res   <= model_result();
            m_mwd   <= (MemWrite1_IN && fwd_hit(RegisterB1_IN)) ? BypassData1_MEMEXE
                                                                 : MemWriteData1_IN;
            m_alt   <= Alt_PC;
            m_wreg  <= WriteRegister1_IN;
            m_ctl   <= ALU_Control1_IN;
            m_rw    <= RegWrite1_IN;
            m_mr    <= MemRead1_IN;
            m_mw    <= MemWrite1_IN;
            m_req   <= Request_Alt_PC;
            m_pred  <= Branch_prediction_IN;
        end
    end

    // Per-cycle comparison on the falling edge, away from input changes
    always @(negedge CLK) begin
        if (m_started) begin
            chk("instr", Instr1_OUT, m_instr);
            chk("pc", Instr1_PC_OUT, m_pc);
            chk("alu_result", ALU_result1_OUT, m_res);
            chk("wreg", {27'd0, WriteRegister1_OUT}, {27'd0, m_wreg});
            chk("store_data", MemWriteData1_OUT, m_mwd);
            chk("regwrite", {31'd0, RegWrite1_OUT}, {31'd0, m_rw});
            chk("alu_ctl", {26'd0, ALU_Control1_OUT}, {26'd0, m_ctl});
            chk("memread", {31'd0, MemRead1_OUT}, {31'd0, m_mr});
            chk("memwrite", {31'd0, MemWrite1_OUT}, {31'd0, m_mw});
            chk("alt_pc", Alt_PC1, m_alt);
            chk("req_alt_pc", {31'd0, Request_Alt_PC1}, {31'd0, m_req});
            chk("pred", {31'd0, Branch_prediction_OUT}, {31'd0, m_pred});
`ifdef FORWARDING_EN
            chk("async_result", ALU_result_async1, model_result());
            chk("async_valid", {31'd0, ALU_result_async_valid1},
                {31'd0, RegWrite1_IN & ~MemRead1_IN & ~FLUSH});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic randomize_inputs();
        Instr1_IN            = $urandom;
        Instr1_PC_IN         = $urandom;
        Request_Alt_PC       = 1'($urandom);
        Alt_PC               = $urandom;
        Branch_prediction_IN = 1'($urandom);
        RegisterA1_IN        = 5'($urandom_range(0, 3));
        RegisterB1_IN        = 5'($urandom_range(0, 3));
        OperandA1_IN         = $urandom;
        OperandB1_IN         = $urandom;
        WriteRegister1_IN    = 5'($urandom);
        MemWriteData1_IN     = $urandom;
        RegWrite1_IN         = 1'($urandom);
        ALU_Control1_IN      = 6'($urandom_range(0, 20));
        MemRead1_IN          = 1'($urandom);
        MemWrite1_IN         = 1'($urandom);
        ShiftAmount1_IN      = 5'($urandom);
        BypassReg1_MEMEXE    = 5'($urandom_range(0, 3));
        BypassData1_MEMEXE   = $urandom;
        BypassValid1_MEMEXE  = 1'($urandom);
    endtask

    task automatic run_alu(input string nm, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [31:0] pc,
                           input logic [31:0] exp);
        RESET = 1'b1; FLUSH = 1'b0; BypassValid1_MEMEXE = 1'b0;
        RegisterA1_IN = '0; RegisterB1_IN = '0;
        ALU_Control1_IN = op; OperandA1_IN = a; OperandB1_IN = b;
        ShiftAmount1_IN = sh; Instr1_PC_IN = pc;
        @(posedge CLK); #1;
        chk(nm, ALU_result1_OUT, exp);
    endtask

    initial begin
        // Reset held two cycles with busy inputs
        randomize_inputs();
        Instr1_IN = 32'hDEAD_BEEF; RegWrite1_IN = 1'b1; Request_Alt_PC = 1'b1;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_instr", Instr1_OUT, 32'd0);
        chk("rst_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
        chk("rst_req_alt", {31'd0, Request_Alt_PC1}, 32'd0);

        // Release: first edge latches the inputs
        Instr1_IN = 32'h1234_5678;
        run_alu("add_ovf", 6'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h100, 32'h8000_0000);
        chk("release_instr", Instr1_OUT, 32'h1234_5678);
        run_alu("sub", 6'd2, 32'd5, 32'd7, 5'd0, 32'h100, 32'hFFFF_FFFE);
        run_alu("slt", 6'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h100, 32'd1);
        run_alu("sltu", 6'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h100, 32'd0);
        run_alu("sra", 6'd12, 32'd0, 32'h8000_0000, 5'd4, 32'h100, 32'hF800_0000);
        run_alu("lui", 6'd16, 32'd0, 32'h0000_1234, 5'd0, 32'h100, 32'h1234_0000);
        run_alu("link", 6'd17, 32'd0, 32'd0, 5'd0, 32'h400, 32'h408);
        run_alu("bad_op", 6'd40, 32'd3, 32'd4, 5'd0, 32'h100, 32'd0);

        // Branch redirect passes through
        Request_Alt_PC = 1'b1; Alt_PC = 32'h1000; Branch_prediction_IN = 1'b0;
        @(posedge CLK); #1;
        chk("br_req", {31'd0, Request_Alt_PC1}, 32'd1);
        chk("br_alt", Alt_PC1, 32'h1000);
        chk("br_pred", {31'd0, Branch_prediction_OUT}, 32'd0);

        // Flush latches a bubble
        FLUSH = 1'b1; RegWrite1_IN = 1'b1; MemWrite1_IN = 1'b1; Request_Alt_PC = 1'b1;
        Branch_prediction_IN = 1'b1;
        @(posedge CLK); #1;
        chk("fl_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
        chk("fl_memwrite", {31'd0, MemWrite1_OUT}, 32'd0);
        chk("fl_req_alt", {31'd0, Request_Alt_PC1}, 32'd0);
        chk("fl_instr", Instr1_OUT, 32'd0);
        FLUSH = 1'b0;

`ifdef FORWARDING_EN
        ALU_Control1_IN = 6'd0; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0; RegWrite1_IN = 1'b1;
        RegisterA1_IN = 5'd5; RegisterB1_IN = 5'd0; OperandA1_IN = 32'd1; OperandB1_IN = 32'd2;
        BypassValid1_MEMEXE = 1'b1; BypassReg1_MEMEXE = 5'd5; BypassData1_MEMEXE = 32'd10;
        #1;
        chk("fwd_async", ALU_result_async1, 32'd12);
        @(posedge CLK); #1;
        chk("fwd_reg", ALU_result1_OUT, 32'd12);
        RegisterA1_IN = 5'd0; BypassReg1_MEMEXE = 5'd0;
        #1;
        chk("fwd_zero_async", ALU_result_async1, 32'd3);
        MemRead1_IN = 1'b1;
        #1;
        chk("load_async_valid", {31'd0, ALU_result_async_valid1}, 32'd0);
        MemRead1_IN = 1'b0; MemWrite1_IN = 1'b1; RegWrite1_IN = 1'b0;
        RegisterB1_IN = 5'd7; BypassReg1_MEMEXE = 5'd7; BypassData1_MEMEXE = 32'hAB;
        MemWriteData1_IN = 32'h55;
        @(posedge CLK); #1;
        chk("fwd_store", MemWriteData1_OUT, 32'hAB);
`endif

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            RESET = ($urandom_range(0, 31) != 0);
            FLUSH = ($urandom_range(0, 7) == 0);
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS core; sits between the ID stage and the MEM stage.
- Computes the ALU result for the instruction delivered by ID and forwards store data.
- Passes the branch redirect and prediction bit through to MEM.
- Registers everything into the EXE/MEM pipeline latch, and exposes a combinational result so ID can bypass from it.

Parameters:
- None. Data width is fixed at 32 bits.

Ports:
- CLK  in  1  Clock; all state updates on the rising edge.
- RESET  in  1  Synchronous, active-low reset.
- FLUSH  in  1  Squash from MEM on branch mispredict.
- Instr1_IN  in  32  Instruction word.
- Instr1_PC_IN  in  32  PC of the instruction.
- Request_Alt_PC  in  1  Redirect request computed in ID.
- Alt_PC  in  32  Redirect target.
- Branch_prediction_IN  in  1  Predictor's taken bit.
- RegisterA1_IN  in  5  Source register A (FORWARDING_EN only).
- RegisterB1_IN  in  5  Source register B (FORWARDING_EN only).
- OperandA1_IN  in  32  Operand A.
- OperandB1_IN  in  32  Operand B (or immediate).
- WriteRegister1_IN  in  5  Destination register.
- MemWriteData1_IN  in  32  Store data.
- RegWrite1_IN  in  1  Register write enable.
- ALU_Control1_IN  in  6  ALU operation.
- MemRead1_IN  in  1  Load.
- MemWrite1_IN  in  1  Store.
- ShiftAmount1_IN  in  5  shamt field.
- BypassReg1_MEMEXE  in  5  MEM/WB destination register (FORWARDING_EN only).
- BypassData1_MEMEXE  in  32  MEM/WB write data (FORWARDING_EN only).
- BypassValid1_MEMEXE  in  1  MEM/WB write valid (FORWARDING_EN only).
- Instr1_OUT  out  32  Registered copy of Instr1_IN.
- Instr1_PC_OUT  out  32  Registered copy of Instr1_PC_IN.
- ALU_result1_OUT  out  32  Registered ALU result.
- WriteRegister1_OUT  out  5  Registered destination register.
- MemWriteData1_OUT  out  32  Registered store data.
- RegWrite1_OUT  out  1  Registered register write enable.
- ALU_Control1_OUT  out  6  Registered ALU operation.
- MemRead1_OUT  out  1  Registered load flag.
- MemWrite1_OUT  out  1  Registered store flag.
- Alt_PC1  out  32  Registered redirect target.
- Request_Alt_PC1  out  1  Registered redirect request.
- Branch_prediction_OUT  out  1  Registered prediction bit.
- ALU_result_async1  out  32  Combinational ALU result (FORWARDING_EN only).
- ALU_result_async_valid1  out  1  Combinational result valid (FORWARDING_EN only).

Behaviour:
- ALU operation codes (A = effective operand A, B = effective operand B):
  - 0 ADD, 1 ADDU: A+B (no overflow trap).
  - 2 SUB, 3 SUBU: A-B.
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT: signed A<B ? 1 : 0.
  - 9 SLTU: unsigned A<B ? 1 : 0.
  - 10 SLL: B<<shamt. 11 SRL: B>>shamt (logical). 12 SRA: B>>>shamt (arithmetic).
  - 13 SLLV, 14 SRLV, 15 SRAV: same shifts, amount = A[4:0].
  - 16 LUI: B<<16.
  - 17 LINK: Instr1_PC_IN+8.
  - Any other code: result 0.
- Loads and stores use code 0; the result is the memory address.
- Pipeline latch, one-cycle latency; all *_OUT, Alt_PC1 and Request_Alt_PC1 are registered.
- Priority on each rising edge:
  1. RESET==0: every registered output is 0.
  2. Else if FLUSH==1: latch a bubble. All outputs are 0, including RegWrite, MemRead, MemWrite, Request_Alt_PC1 and Branch_prediction_OUT.
  3. Else: latch the computed result and pass all other inputs through.
- There is no stall input. ID holds its outputs as a bubble while it is frozen.
- Arithmetic is 32-bit; carries out of bit 31 are discarded.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined, operand A selection:
  - A = BypassData1_MEMEXE when BypassValid1_MEMEXE==1, BypassReg1_MEMEXE==RegisterA1_IN, and RegisterA1_IN!=0.
  - Otherwise A = OperandA1_IN.
- Defined, B selection: identical rule using RegisterB1_IN. The same forwarded value also replaces MemWriteData1_IN when MemWrite1_IN==1.
- Defined, bypass outputs:
  - ALU_result_async1 = the combinational result.
  - ALU_result_async_valid1 = RegWrite1_IN & ~MemRead1_IN & ~FLUSH.
- Not defined:
  - RegisterA1_IN, RegisterB1_IN, the Bypass*_MEMEXE inputs and the async outputs do not exist.
  - Operands are used as delivered.

Test Plan:
- RESET=0 held for 2 cycles with nonzero inputs → all outputs 0 after the edge. Release → the next edge latches the inputs.
- ALU codes:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 5-7 → 0xFFFFFFFE.
  - SLT A=0xFFFFFFFF, B=1 → 1; SLTU with the same operands → 0.
  - SRA B=0x80000000, shamt=4 → 0xF8000000.
  - LUI B=0x1234 → 0x12340000.
  - LINK with PC=0x400 → 0x408.
- Request_Alt_PC=1, Alt_PC=0x1000, Branch_prediction_IN=0 → the next cycle Request_Alt_PC1=1, Alt_PC1=0x1000, Branch_prediction_OUT=0.
- FLUSH=1 with RegWrite1_IN=1, MemWrite1_IN=1, Request_Alt_PC=1 → the next cycle RegWrite1_OUT=0, MemWrite1_OUT=0, Request_Alt_PC1=0, Instr1_OUT=0.
- FORWARDING_EN, bypass match:
  - Setup: RegisterA1_IN=5, OperandA1_IN=1, OperandB1_IN=2, ADD.
  - Bypass inputs: valid=1, reg=5, data=10.
  - Expected: ALU_result_async1=12, registered result 12. With reg=0 on both sides → 3.
- FORWARDING_EN, load: MemRead1_IN=1, RegWrite1_IN=1 → ALU_result_async_valid1=0. Store with RegisterB1_IN matching the bypass (data=0xAB) → MemWriteData1_OUT=0xAB.
